mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS pipeline memory stage, directly downstream of the execute stage; consumes its EX/MEM bundle (WB/M control, branch address, zero flag, ALU result, store data, destination register).
- Performs data-memory load/store against an internal word array with configurable wait states, resolving the branch decision (PCSrc) for fetch.
- Registers the MEM/WB bundle for write-back.
- Stalls upstream while a multi-cycle access is in flight.

Parameters:
- DEPTH_LOG2, 8, log2 of data-memory depth in 32-bit words.
- WAIT_CYCLES, 0, extra cycles per load/store (0 = single-cycle access); legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  EX/MEM bundle valid this cycle.
- in_WB  in  2  [1]=regWrite, [0]=memToReg; passed through.
- in_M  in  3  [2]=branch, [1]=memRead, [0]=memWrite.
- in_branch_address  in  32  branch target from execute.
- in_zero_flag  in  1  ALU zero.
- in_ALU_result  in  32  memory byte address / ALU value.
- in_reg_write_data  in  32  store data.
- in_rd  in  5  destination register.
- stall  out  1  upstream must hold its bundle stable and not advance.
- pc_src  out  1  take branch (combinational).
- branch_target  out  32  equals in_branch_address.
- out_valid  out  1  MEM/WB bundle valid.
- out_WB  out  2  registered in_WB.
- out_read_data  out  32  loaded word.
- out_ALU_result  out  32  registered ALU result.
- out_rd  out  5  registered rd.
- out_misaligned  out  1  see Optional Feature.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, wait counter=0.
  - All registered outputs 0: out_valid, out_WB, out_read_data, out_ALU_result, out_rd, out_misaligned.
  - Memory array contents are not reset; the array is zero at simulation start.
- Reset mid-WAIT aborts the access: a pending store is dropped and no out_valid is produced.
- Word index = in_ALU_result[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses wrap modulo the array size.
- Memory op (memop) = memRead | memWrite. When both are set, the write wins and out_read_data=0.
- Accept = in_valid & ~stall.
- FSM states: IDLE, WAIT.
- IDLE, accept, and (no memop or WAIT_CYCLES=0):
  - At the posedge, perform the store, or register the combinational array read.
  - Capture the MEM/WB bundle and set out_valid=1 for the next cycle.
  - Latency: 1 cycle.
- IDLE, accept, memop, WAIT_CYCLES=W>0:
  - Latch the bundle internally, load counter=W, go to WAIT.
  - out_valid=0 next cycle.
- WAIT:
  - stall=1.
  - Counter decrements each cycle.
  - On the posedge where counter==1: perform the access using the latched bundle, update MEM/WB, set out_valid=1, return to IDLE.
  - stall is high for exactly W cycles; results appear W+1 posedges after acceptance.
  - in_valid is ignored while stall=1.
- No accept: out_valid=0 next cycle; other MEM/WB fields hold.
- Non-memop bundles: out_read_data=0.
- pc_src = accept & in_M[2] & in_zero_flag; 0 during stall and reset.
- Stores commit exactly once per accepted memWrite; a load issued the cycle after a store to the same address returns the new data.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: a memop with in_ALU_result[1:0]!=0 completes in 1 cycle with no wait states.
  - No store is performed.
  - out_read_data=0.
  - out_WB[1] is forced to 0.
  - out_misaligned=1 with out_valid.
- Undefined: address bits [1:0] are ignored and out_misaligned is tied 0.

Test Plan:
- WAIT_CYCLES=0: store 0xDEADBEEF to addr 0x10, then load addr 0x10 next cycle -> out_read_data=0xDEADBEEF, out_valid one cycle after each, stall never 1.
- WAIT_CYCLES=3: accept load at cycle N -> stall=1 cycles N+1..N+3, out_valid=1 only in cycle N+4 with correct data; a different bundle driven on in_valid during stall is ignored.
- Branch: in_M=3'b100, in_zero_flag=1, in_branch_address=0x40 -> pc_src=1, branch_target=0x40 same cycle. Repeat with in_zero_flag=0 -> pc_src=0.
- Wrap: DEPTH_LOG2=8; store 0x1 to addr 0x400, load addr 0x0 -> 0x1. Set both memRead and memWrite -> store occurs, out_read_data=0.
- rst_n=0 during WAIT of a store (WAIT_CYCLES=2) -> next cycle stall=0, out_valid=0; subsequent load of that address returns the old value.
- MEM_ALIGN_CHECK_EN defined: load addr 0x13 with in_WB=2'b11 -> out_misaligned=1, out_WB=2'b01, out_read_data=0, no stall.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MIPS pipeline memory stage.
// - Performs loads and stores against an internal word array.
// - WAIT_CYCLES adds wait states to every load or store, and stalls upstream while one is in flight.
// - Resolves the branch decision (pc_src) for fetch.
// - Registers the MEM/WB bundle for write-back.
// Optional build macro MEM_ALIGN_CHECK_EN: flags misaligned word accesses
// and suppresses their effect instead of ignoring address bits [1:0].
module mem_stage #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  in_WB,
    input  logic [2:0]  in_M,
    input  logic [31:0] in_branch_address,
    input  logic        in_zero_flag,
    input  logic [31:0] in_ALU_result,
    input  logic [31:0] in_reg_write_data,
    input  logic [4:0]  in_rd,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        out_valid,
    output logic [1:0]  out_WB,
    output logic [31:0] out_read_data,
    output logic [31:0] out_ALU_result,
    output logic [4:0]  out_rd,
    output logic        out_misaligned
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Bundle held while a wait-stated access is in flight
    logic [1:0]          lat_wb;
    logic [1:0]          lat_m;
    logic [DATA_W-1:0]   lat_alu;
    logic [DATA_W-1:0]   lat_wdata;
    logic [REG_W-1:0]    lat_rd;

    logic                accept;
    logic                go_wait;
    logic                fire_now;
    logic                fire_wait;
    logic                fire;
    logic                memop_in;
    logic                mis_in;

    logic [1:0]          sel_wb;
    logic [1:0]          sel_m;
    logic [DATA_W-1:0]   sel_alu;
    logic [DATA_W-1:0]   sel_wdata;
    logic [REG_W-1:0]    sel_rd;
    logic                sel_mis;
    logic [DEPTH_LOG2-1:0] idx;
    logic                store_en;
    logic [DATA_W-1:0]   rdata_val;
    logic [1:0]          wb_val;

    assign memop_in      = in_M[1] | in_M[0];
    assign branch_target = in_branch_address;
    assign fire          = fire_now | fire_wait;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_in = memop_in & (in_ALU_result[1:0] != 2'b00);
`else
    assign mis_in = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: enter WAIT on a wait-stated access, leave on the last wait cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_wait) state_nxt = WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: stall, acceptance, access strobes and branch decision
    always_comb begin
        stall     = 1'b0;
        accept    = 1'b0;
        go_wait   = 1'b0;
        fire_now  = 1'b0;
        fire_wait = 1'b0;
        pc_src    = 1'b0;
        case (state)
            IDLE: begin
                accept   = in_valid & rst_n;
                go_wait  = accept & memop_in & ~mis_in & HAS_WAIT;
                fire_now = accept & ~go_wait;
                pc_src   = accept & in_M[2] & in_zero_flag;
            end
            WAIT: begin
                stall     = 1'b1;
                fire_wait = rst_n & (cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

    // Access source: live inputs in IDLE, latched bundle while waiting
    always_comb begin
        sel_wb    = in_WB;
        sel_m     = in_M[1:0];
        sel_alu   = in_ALU_result;
        sel_wdata = in_reg_write_data;
        sel_rd    = in_rd;
        sel_mis   = mis_in;
        if (state == WAIT) begin
            sel_wb    = lat_wb;
            sel_m     = lat_m;
            sel_alu   = lat_alu;
            sel_wdata = lat_wdata;
            sel_rd    = lat_rd;
            sel_mis   = 1'b0;
        end
        idx       = sel_alu[DEPTH_LOG2+1:2];
        store_en  = fire & sel_m[0] & ~sel_mis;
        rdata_val = '0;
        if (sel_m[1] & ~sel_m[0] & ~sel_mis) begin
            rdata_val = mem[idx];
        end
        wb_val = sel_mis ? {1'b0, sel_wb[0]} : sel_wb;
    end

    // Data array write port; contents are never reset
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[idx] <= sel_wdata;
        end
    end

    // MEM/WB register, bundle latch and wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            lat_wb         <= '0;
            lat_m          <= '0;
            lat_alu        <= '0;
            lat_wdata      <= '0;
            lat_rd         <= '0;
            out_valid      <= 1'b0;
            out_WB         <= '0;
            out_read_data  <= '0;
            out_ALU_result <= '0;
            out_rd         <= '0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                out_WB         <= wb_val;
                out_read_data  <= rdata_val;
                out_ALU_result <= sel_alu;
                out_rd         <= sel_rd;
            end
            if (go_wait) begin
                lat_wb    <= in_WB;
                lat_m     <= in_M[1:0];
                lat_alu   <= in_ALU_result;
                lat_wdata <= in_reg_write_data;
                lat_rd    <= in_rd;
                cnt       <= WAIT_LOAD;
            end else if (stall) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Misalignment flag travels with the MEM/WB bundle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_misaligned <= 1'b0;
        end else if (fire) begin
            out_misaligned <= sel_mis;
        end
    end
`else
    assign out_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: three mem_stage instances (WAIT_CYCLES 0, 3, 2) checked against
// a transaction-level model of the data memory and MEM/WB results.
module tb_mem_stage;

    localparam int NDUT = 3;
    localparam int unsigned W0 = 0;
    localparam int unsigned W1 = 3;
    localparam int unsigned W2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn   [NDUT];
    logic        v_in   [NDUT];
    logic [1:0]  wb_in  [NDUT];
    logic [2:0]  m_in   [NDUT];
    logic [31:0] ba_in  [NDUT];
    logic        z_in   [NDUT];
    logic [31:0] alu_in [NDUT];
    logic [31:0] wd_in  [NDUT];
    logic [4:0]  rd_in  [NDUT];

    logic        stall_o [NDUT];
    logic        pcs_o   [NDUT];
    logic [31:0] bt_o    [NDUT];
    logic        ov_o    [NDUT];
    logic [1:0]  wb_o    [NDUT];
    logic [31:0] rdat_o  [NDUT];
    logic [31:0] alu_o   [NDUT];
    logic [4:0]  rd_o    [NDUT];
    logic        mis_o   [NDUT];

    mem_stage #(.DEPTH_LOG2(8), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst_n(rstn[0]), .in_valid(v_in[0]), .in_WB(wb_in[0]), .in_M(m_in[0]),
        .in_branch_address(ba_in[0]), .in_zero_flag(z_in[0]), .in_ALU_result(alu_in[0]),
        .in_reg_write_data(wd_in[0]), .in_rd(rd_in[0]), .stall(stall_o[0]), .pc_src(pcs_o[0]),
        .branch_target(bt_o[0]), .out_valid(ov_o[0]), .out_WB(wb_o[0]), .out_read_data(rdat_o[0]),
        .out_ALU_result(alu_o[0]), .out_rd(rd_o[0]), .out_misaligned(mis_o[0])
    );

    mem_stage #(.DEPTH_LOG2(8), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst_n(rstn[1]), .in_valid(v_in[1]), .in_WB(wb_in[1]), .in_M(m_in[1]),
        .in_branch_address(ba_in[1]), .in_zero_flag(z_in[1]), .in_ALU_result(alu_in[1]),
        .in_reg_write_data(wd_in[1]), .in_rd(rd_in[1]), .stall(stall_o[1]), .pc_src(pcs_o[1]),
        .branch_target(bt_o[1]), .out_valid(ov_o[1]), .out_WB(wb_o[1]), .out_read_data(rdat_o[1]),
        .out_ALU_result(alu_o[1]), .out_rd(rd_o[1]), .out_misaligned(mis_o[1])
    );

    mem_stage #(.DEPTH_LOG2(8), .WAIT_CYCLES(W2)) u_dut2 (
        .clk(clk), .rst_n(rstn[2]), .in_valid(v_in[2]), .in_WB(wb_in[2]), .in_M(m_in[2]),
        .in_branch_address(ba_in[2]), .in_zero_flag(z_in[2]), .in_ALU_result(alu_in[2]),
        .in_reg_write_data(wd_in[2]), .in_rd(rd_in[2]), .stall(stall_o[2]), .pc_src(pcs_o[2]),
        .branch_target(bt_o[2]), .out_valid(ov_o[2]), .out_WB(wb_o[2]), .out_read_data(rdat_o[2]),
        .out_ALU_result(alu_o[2]), .out_rd(rd_o[2]), .out_misaligned(mis_o[2])
    );

    // Observed / expected outcome of one transaction
    typedef struct packed {
        logic [7:0]  stalls;
        logic        pcs;
        logic [31:0] bt;
        logic        pcs_in_stall;
        logic        timeout;
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mis;
    } res_t;

    logic [31:0] mmem [NDUT][256];
    int n_checks;
    int n_fail;

    function automatic int wait_of(input int d);
        case (d)
            0:       return W0;
            1:       return W1;
            default: return W2;
        endcase
    endfunction

    // Reference model: word memory of 256 entries, byte address / 4 modulo 256
    task automatic model_txn(input int d, input logic [1:0] wb, input logic [2:0] m,
                             input logic [31:0] ba, input logic z, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [4:0] rd, output res_t e);
        bit memop;
        bit mis;
        int unsigned idx;
        memop = (m[1] == 1'b1) || (m[0] == 1'b1);
        mis   = 1'b0;
        idx   = (alu / 4) % 256;
`ifdef MEM_ALIGN_CHECK_EN
        mis = memop && ((alu % 4) != 0);
`endif
        e = '0;
        e.pcs    = m[2] & z;
        e.bt     = ba;
        e.alu    = alu;
        e.rd     = rd;
        e.mis    = mis;
        e.wb     = mis ? {1'b0, wb[0]} : wb;
        e.stalls = (memop && !mis) ? 8'(wait_of(d)) : 8'd0;
        if (!mis && m[0] == 1'b1) begin
            mmem[d][idx] = wd;
        end else if (!mis && m[1] == 1'b1) begin
            e.rdata = mmem[d][idx];
        end
    endtask

    // Drive one bundle, feed a conflicting store bundle during stall, capture the result
    task automatic issue(input int d, input logic [1:0] wb, input logic [2:0] m,
                         input logic [31:0] ba, input logic z, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd, output res_t o);
        bit got;
        got = 1'b0;
        o = '0;
        @(negedge clk);
        v_in[d] = 1'b1; wb_in[d] = wb; m_in[d] = m; ba_in[d] = ba; z_in[d] = z;
        alu_in[d] = alu; wd_in[d] = wd; rd_in[d] = rd;
        #1;
        o.pcs = pcs_o[d];
        o.bt  = bt_o[d];
        @(posedge clk);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ov_o[d]) begin
                got     = 1'b1;
                o.wb    = wb_o[d];
                o.rdata = rdat_o[d];
                o.alu   = alu_o[d];
                o.rd    = rd_o[d];
                o.mis   = mis_o[d];
            end else if (stall_o[d]) begin
                o.stalls = o.stalls + 8'd1;
                v_in[d]  = 1'b1; m_in[d] = 3'b101; z_in[d] = 1'b1;
                ba_in[d] = $urandom; wd_in[d] = $urandom;
                wb_in[d] = 2'($urandom); rd_in[d] = 5'($urandom);
                #1;
                if (pcs_o[d]) o.pcs_in_stall = 1'b1;
            end else begin
                v_in[d] = 1'b0;
            end
        end
        v_in[d] = 1'b0;
        if (!got) o.timeout = 1'b1;
    endtask

    task automatic test_reset();
        logic [74:0] obs;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            obs = {stall_o[d], pcs_o[d], ov_o[d], wb_o[d], rdat_o[d], alu_o[d], rd_o[d], mis_o[d]};
            n_checks++;
            if (obs !== 75'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h want 0", d, obs);
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            v_in[d] = 1'b0;
            rstn[d] = 1'b1;
        end
    endtask

    task automatic test_store_load_w0();
        res_t e1, e2;
        logic [72:0] obs, exp_v;
        model_txn(0, 2'b00, 3'b001, 32'h0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, e1);
        model_txn(0, 2'b11, 3'b010, 32'h0, 1'b0, 32'h10, 32'h0, 5'd7, e2);
        @(negedge clk);
        v_in[0] = 1'b1; wb_in[0] = 2'b00; m_in[0] = 3'b001; z_in[0] = 1'b0;
        alu_in[0] = 32'h10; wd_in[0] = 32'hDEADBEEF; rd_in[0] = 5'd0;
        @(posedge clk);
        @(negedge clk);
        obs   = {ov_o[0], stall_o[0], wb_o[0], rdat_o[0], alu_o[0], rd_o[0]};
        exp_v = {1'b1, 1'b0, e1.wb, e1.rdata, e1.alu, e1.rd};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL w0_store: got %h want %h", obs, exp_v);
        end
        wb_in[0] = 2'b11; m_in[0] = 3'b010; wd_in[0] = 32'h0; rd_in[0] = 5'd7;
        @(posedge clk);
        @(negedge clk);
        obs   = {ov_o[0], stall_o[0], wb_o[0], rdat_o[0], alu_o[0], rd_o[0]};
        exp_v = {1'b1, 1'b0, e2.wb, e2.rdata, e2.alu, e2.rd};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL w0_load_after_store: got %h want %h", obs, exp_v);
        end
        v_in[0] = 1'b0;
    endtask

    task automatic test_wait_cycles();
        res_t e, o;
        logic [71:0] obs, exp_v;
        model_txn(1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h24, 32'h12345678, 5'd3, e);
        issue(1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h24, 32'h12345678, 5'd3, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL w3_store: got %h want %h", o, e); end
        model_txn(1, 2'b10, 3'b010, 32'h0, 1'b0, 32'h24, 32'h0, 5'd4, e);
        issue(1, 2'b10, 3'b010, 32'h0, 1'b0, 32'h24, 32'h0, 5'd4, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL w3_load: got %h want %h", o, e); end
        @(posedge clk);
        @(negedge clk);
        obs   = {ov_o[1], wb_o[1], rdat_o[1], alu_o[1], rd_o[1]};
        exp_v = {1'b0, e.wb, e.rdata, e.alu, e.rd};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL w3_idle_hold: got %h want %h", obs, exp_v); end
        model_txn(1, 2'b10, 3'b010, 32'h0, 1'b0, 32'h24, 32'h0, 5'd5, e);
        issue(1, 2'b10, 3'b010, 32'h0, 1'b0, 32'h24, 32'h0, 5'd5, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL w3_reload: got %h want %h", o, e); end
    endtask

    task automatic test_branch();
        res_t e, o;
        model_txn(0, 2'b00, 3'b100, 32'h40, 1'b1, 32'h8, 32'h0, 5'd0, e);
        issue(0, 2'b00, 3'b100, 32'h40, 1'b1, 32'h8, 32'h0, 5'd0, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL branch_taken: got %h want %h", o, e); end
        model_txn(0, 2'b00, 3'b100, 32'h40, 1'b0, 32'h8, 32'h0, 5'd0, e);
        issue(0, 2'b00, 3'b100, 32'h40, 1'b0, 32'h8, 32'h0, 5'd0, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL branch_not_taken: got %h want %h", o, e); end
        model_txn(1, 2'b00, 3'b100, 32'h80, 1'b1, 32'h0, 32'h0, 5'd1, e);
        issue(1, 2'b00, 3'b100, 32'h80, 1'b1, 32'h0, 32'h0, 5'd1, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL branch_w3_nomem: got %h want %h", o, e); end
        model_txn(1, 2'b11, 3'b110, 32'hC0, 1'b1, 32'h24, 32'h0, 5'd2, e);
        issue(1, 2'b11, 3'b110, 32'hC0, 1'b1, 32'h24, 32'h0, 5'd2, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL branch_w3_load: got %h want %h", o, e); end
    endtask

    task automatic test_wrap();
        res_t e, o;
        for (int d = 0; d < NDUT; d += 2) begin
            model_txn(d, 2'b00, 3'b001, 32'h0, 1'b0, 32'h400, 32'h1, 5'd0, e);
            issue(d, 2'b00, 3'b001, 32'h0, 1'b0, 32'h400, 32'h1, 5'd0, o);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wrap_store dut%0d: got %h want %h", d, o, e); end
            model_txn(d, 2'b11, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0, 5'd9, e);
            issue(d, 2'b11, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0, 5'd9, o);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wrap_load dut%0d: got %h want %h", d, o, e); end
            model_txn(d, 2'b11, 3'b011, 32'h0, 1'b0, 32'h8, 32'h55, 5'd10, e);
            issue(d, 2'b11, 3'b011, 32'h0, 1'b0, 32'h8, 32'h55, 5'd10, o);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL both_rw dut%0d: got %h want %h", d, o, e); end
            model_txn(d, 2'b11, 3'b010, 32'h0, 1'b0, 32'h8, 32'h0, 5'd11, e);
            issue(d, 2'b11, 3'b010, 32'h0, 1'b0, 32'h8, 32'h0, 5'd11, o);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL both_rw_readback dut%0d: got %h want %h", d, o, e); end
        end
    endtask

    task automatic test_reset_mid_wait();
        res_t e, o;
        logic [3:0] obs;
        model_txn(2, 2'b00, 3'b001, 32'h0, 1'b0, 32'h30, 32'h11111111, 5'd0, e);
        issue(2, 2'b00, 3'b001, 32'h0, 1'b0, 32'h30, 32'h11111111, 5'd0, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL rst_pre_store: got %h want %h", o, e); end
        @(negedge clk);
        v_in[2] = 1'b1; wb_in[2] = 2'b00; m_in[2] = 3'b001; z_in[2] = 1'b0;
        alu_in[2] = 32'h30; wd_in[2] = 32'h22222222; rd_in[2] = 5'd0;
        @(posedge clk);
        @(negedge clk);
        obs[3]  = stall_o[2];
        v_in[2] = 1'b0;
        rstn[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        obs[2]  = stall_o[2];
        obs[1]  = ov_o[2];
        rstn[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obs[0]  = ov_o[2];
        n_checks++;
        if (obs !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_wait: got %b want 1000", obs); end
        model_txn(2, 2'b10, 3'b010, 32'h0, 1'b0, 32'h30, 32'h0, 5'd6, e);
        issue(2, 2'b10, 3'b010, 32'h0, 1'b0, 32'h30, 32'h0, 5'd6, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL rst_dropped_store: got %h want %h", o, e); end
    endtask

    task automatic test_misaligned();
        res_t e, o;
        model_txn(1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h10, 32'hCAFE0001, 5'd0, e);
        issue(1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h10, 32'hCAFE0001, 5'd0, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL mis_setup: got %h want %h", o, e); end
        model_txn(1, 2'b11, 3'b010, 32'h0, 1'b0, 32'h13, 32'h0, 5'd9, e);
        issue(1, 2'b11, 3'b010, 32'h0, 1'b0, 32'h13, 32'h0, 5'd9, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL mis_load: got %h want %h", o, e); end
        model_txn(1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h12, 32'h00000BAD, 5'd0, e);
        issue(1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h12, 32'h00000BAD, 5'd0, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL mis_store: got %h want %h", o, e); end
        model_txn(1, 2'b10, 3'b010, 32'h0, 1'b0, 32'h10, 32'h0, 5'd8, e);
        issue(1, 2'b10, 3'b010, 32'h0, 1'b0, 32'h10, 32'h0, 5'd8, o);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL mis_readback: got %h want %h", o, e); end
    endtask

    task automatic test_random();
        res_t e, o;
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 30; n++) begin
                logic [31:0] alu;
                logic [1:0]  wb;
                logic [2:0]  m;
                logic [31:0] ba;
                logic [31:0] wd;
                logic [4:0]  rd;
                logic        z;
                int unsigned hi;
                int unsigned lo;
                hi  = ($urandom_range(0, 3) == 0) ? ($urandom >> 10) : $urandom_range(0, 1);
                lo  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 0;
                alu = 32'(hi * 1024 + $urandom_range(0, 7) * 4 + lo);
                wb  = 2'($urandom);
                m   = 3'($urandom);
                ba  = $urandom;
                wd  = $urandom;
                rd  = 5'($urandom);
                z   = 1'($urandom);
                model_txn(d, wb, m, ba, z, alu, wd, rd, e);
                issue(d, wb, m, ba, z, alu, wd, rd, o);
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL random dut%0d txn%0d: got %h want %h", d, n, o, e);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < NDUT; d++) begin
            rstn[d] = 1'b0; v_in[d] = 1'b1; wb_in[d] = 2'b11; m_in[d] = 3'b100;
            ba_in[d] = 32'h40; z_in[d] = 1'b1; alu_in[d] = 32'h0; wd_in[d] = 32'h0; rd_in[d] = 5'd0;
            for (int i = 0; i < 256; i++) mmem[d][i] = 32'h0;
        end
        test_reset();
        test_store_load_w0();
        test_wait_cycles();
        test_branch();
        test_wrap();
        test_reset_mid_wait();
        test_misaligned();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, want finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
